c3lib_ckg_seq_ctrl: RTL

- Sequences the enables of NUM_DOM positive-edge clock gaters (LVT 8x) that each feed one clock domain.
- Each domain requester raises req and receives ack once its gated clock is running and settled.
- Turn-ons are round-robin arbitrated and staggered to limit di/dt.
- Turn-offs follow a programmable idle hysteresis.
- Sits between per-domain request logic and the gater bank; clk_en[i] drives gater i's clk_en and tst_en passes through to the gaters.

---
 rtl/c3lib_ckg_seq_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/c3lib_ckg_seq_ctrl.sv
// Clock-gater enable sequencer: per-domain OFF/PEND/WARM/ON/COOL FSMs with
// round-robin, staggered turn-on grants and idle-hysteresis turn-off.
module c3lib_ckg_seq_ctrl #(
  parameter int unsigned NUM_DOM  = 4,
  parameter int unsigned STAGGER  = 4,
  parameter int unsigned ACK_DLY  = 2,
  parameter int unsigned IDLE_CNT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tst_en,
  input  logic [NUM_DOM-1:0] req,
  output logic [NUM_DOM-1:0] clk_en,
  output logic [NUM_DOM-1:0] ack,
  output logic               all_off
);

  localparam int unsigned CNT_MAX = (ACK_DLY > IDLE_CNT) ? ACK_DLY : IDLE_CNT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned SW      = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int unsigned PW      = $clog2(NUM_DOM);
  localparam int unsigned SUMW    = PW + 1;

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_PEND = 3'd1,
    ST_WARM = 3'd2,
    ST_ON   = 3'd3,
    ST_COOL = 3'd4
  } state_t;

  state_t            state_q [NUM_DOM];
  state_t            state_d [NUM_DOM];
  logic [CW-1:0]     cnt_q   [NUM_DOM];
  logic [CW-1:0]     cnt_d   [NUM_DOM];
  logic [SW-1:0]     stg_q;
  logic [PW-1:0]     ptr_q;
  logic [NUM_DOM-1:0] en_q, ack_q, en_d, ack_d;
  logic              all_off_q, all_off_d;

  logic              gnt_vld;
  logic [PW-1:0]     gnt_idx;
  logic [PW-1:0]     ptr_nxt;
  logic [SUMW-1:0]   sum;
  logic [PW-1:0]     idx;

  // First PEND domain at or after the pointer, wrapping modulo NUM_DOM.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    idx     = '0;
    if (stg_q == '0) begin
      for (int unsigned k = 0; k < NUM_DOM; k++) begin
        sum = {1'b0, ptr_q} + SUMW'(k);
        if (sum >= SUMW'(NUM_DOM)) sum = sum - SUMW'(NUM_DOM);
        idx = sum[PW-1:0];
        if (!gnt_vld && state_q[idx] == ST_PEND) begin
          gnt_vld = 1'b1;
          gnt_idx = idx;
        end
      end
    end
  end

  always_comb begin
    ptr_nxt = (gnt_idx == PW'(NUM_DOM - 1)) ? '0 : gnt_idx + PW'(1);
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (req[i]) state_d[i] = ST_PEND;
        end
        ST_PEND: begin
          if (gnt_vld && gnt_idx == PW'(i)) begin
            state_d[i] = ST_WARM;
            cnt_d[i]   = CW'(ACK_DLY);
          end
        end
        ST_WARM: begin
          if (cnt_q[i] == CW'(1)) state_d[i] = ST_ON;
          else                    cnt_d[i]   = cnt_q[i] - CW'(1);
        end
        ST_ON: begin
          if (!req[i]) begin
            state_d[i] = ST_COOL;
            cnt_d[i]   = CW'(IDLE_CNT);
          end
        end
        ST_COOL: begin
          // A returning request beats an expiring idle count.
          if (req[i])                   state_d[i] = ST_ON;
          else if (cnt_q[i] == CW'(1))  state_d[i] = ST_OFF;
          else                          cnt_d[i]   = cnt_q[i] - CW'(1);
        end
        default: state_d[i] = ST_OFF;
      endcase
    end
  end

  always_comb begin
    en_d      = '0;
    ack_d     = '0;
    all_off_d = 1'b1;
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      en_d[i]  = (state_d[i] == ST_WARM) || (state_d[i] == ST_ON) ||
                 (state_d[i] == ST_COOL);
      ack_d[i] = (state_d[i] == ST_ON) || (state_d[i] == ST_COOL);
      if (state_d[i] != ST_OFF) all_off_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_DOM; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      stg_q     <= '0;
      ptr_q     <= '0;
      en_q      <= '0;
      ack_q     <= '0;
      all_off_q <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_DOM; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      if (gnt_vld) begin
        stg_q <= SW'(STAGGER - 1);
        ptr_q <= ptr_nxt;
      end else if (stg_q != '0) begin
        stg_q <= stg_q - SW'(1);
      end
      en_q      <= en_d;
      ack_q     <= ack_d;
      all_off_q <= all_off_d;
    end
  end

  assign clk_en  = en_q | {NUM_DOM{tst_en}};
  assign ack     = ack_q;
  assign all_off = all_off_q;

endmodule
